// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Host register map and STATUS layout shared by the UART bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_TXCNT  = 2'd2,
    ADDR_RXCNT  = 2'd3
  } host_addr_e;

  // Field order fixes the STATUS bit positions, LSB last.
  typedef struct packed {
    logic [2:0] rsvd;
    logic       tx_full;
    logic       rx_ovf;
    logic       tx_ovf;
    logic       rx_full;
    logic       tx_nempty;
  } status_t;

  localparam int c_st_tx_ovf_bit = 2;
  localparam int c_st_rx_ovf_bit = 3;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_bridge_if
// Description : UART-emulation and host register signals of the FIFO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_fifo_bridge_if;

  logic [7:0] tx_fifo_data;
  logic       tx_fifo_valid;
  logic       tx_fifo_full;
  logic [7:0] rx_fifo_data;
  logic       rx_fifo_valid;
  logic       rx_fifo_read;
  logic [1:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic       host_re;
  logic [7:0] host_rdata;
  logic       host_irq;

  modport master (
    output tx_fifo_data, tx_fifo_valid, rx_fifo_read,
    output host_addr, host_wdata, host_we, host_re,
    input  tx_fifo_full, rx_fifo_data, rx_fifo_valid, host_rdata, host_irq
  );

  modport slave (
    input  tx_fifo_data, tx_fifo_valid, rx_fifo_read,
    input  host_addr, host_wdata, host_we, host_re,
    output tx_fifo_full, rx_fifo_data, rx_fifo_valid, host_rdata, host_irq
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through FIFO with occupancy count and drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_head,
  output logic      [CW-1:0]    o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_drop
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_count   = r_count;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_bridge
// Description : Byte FIFOs between a UART emulation core and a host register port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input wire logic           clk,
  input wire logic           rst_n,
  uart_fifo_bridge_if.slave  bus
);

  logic [7:0]    w_tx_head;
  logic [CW-1:0] w_tx_count;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_tx_drop;
  logic [CW-1:0] w_rx_count;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_rx_drop;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_st_wr;
  status_t       w_status;
  logic [7:0]    w_rdata_nxt;
  logic          r_tx_ovf;
  logic          r_rx_ovf;
  logic [7:0]    r_rdata;
  logic          r_irq;

  assign w_tx_pop  = bus.host_re && (bus.host_addr == ADDR_DATA);
  assign w_rx_push = bus.host_we && (bus.host_addr == ADDR_DATA);
  assign w_st_wr   = bus.host_we && (bus.host_addr == ADDR_STATUS);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.tx_fifo_valid),
    .i_data  (bus.tx_fifo_data),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_count (w_tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_drop  (w_tx_drop)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_data  (bus.host_wdata),
    .i_pop   (bus.rx_fifo_read),
    .o_head  (bus.rx_fifo_data),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_drop  (w_rx_drop)
  );

  // Asserted one entry early so the UART's lagging status view cannot overrun.
  assign bus.tx_fifo_full  = w_tx_full || (w_tx_count == CW'(DEPTH - 1));
  assign bus.rx_fifo_valid = !w_rx_empty;
  assign bus.host_rdata    = r_rdata;
  assign bus.host_irq      = r_irq;

  always_comb begin
    w_status           = '0;
    w_status.tx_nempty = !w_tx_empty;
    w_status.rx_full   = w_rx_full;
    w_status.tx_ovf    = r_tx_ovf;
    w_status.rx_ovf    = r_rx_ovf;
    w_status.tx_full   = bus.tx_fifo_full;
  end

  always_comb begin
    w_rdata_nxt = 8'h00;
    case (bus.host_addr)
      ADDR_DATA:   w_rdata_nxt = w_tx_head;
      ADDR_STATUS: w_rdata_nxt = w_status;
      ADDR_TXCNT:  w_rdata_nxt = 8'(w_tx_count);
      ADDR_RXCNT:  w_rdata_nxt = 8'(w_rx_count);
      default:     w_rdata_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_rdata  <= 8'h00;
      r_irq    <= 1'b0;
    end else begin
      // A drop in the clearing cycle keeps the flag set.
      r_tx_ovf <= w_tx_drop || (r_tx_ovf && !(w_st_wr && bus.host_wdata[c_st_tx_ovf_bit]));
      r_rx_ovf <= w_rx_drop || (r_rx_ovf && !(w_st_wr && bus.host_wdata[c_st_rx_ovf_bit]));
      if (bus.host_re) r_rdata <= w_rdata_nxt;
      r_irq <= !w_tx_empty;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_bridge
// Description : Self-checking bench for uart_fifo_bridge (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_TXC = 2'd2, A_RXC = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_bridge_if bus();

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       tv;
    logic [7:0] td;
    logic       we;
    logic       re;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       rr;
    logic       chk;
    logic [7:0] exp_rdata;
    logic       exp_irq;
    logic       exp_rxv;
    logic [7:0] exp_rxd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  function automatic vec_t mk(string n, logic tv, logic [7:0] td, logic we, logic re,
                              logic [1:0] a, logic [7:0] wd, logic rr, logic chk,
                              logic [7:0] erd, logic eirq, logic erxv, logic [7:0] erxd);
    vec_t v;
    v.name = n; v.tv = tv; v.td = td; v.we = we; v.re = re; v.addr = a; v.wd = wd;
    v.rr = rr; v.chk = chk; v.exp_rdata = erd; v.exp_irq = eirq; v.exp_rxv = erxv;
    v.exp_rxd = erxd;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step(input logic tv, input logic [7:0] td, input logic we, input logic re,
                      input logic [1:0] addr, input logic [7:0] wd, input logic rr);
    @(negedge clk);
    bus.tx_fifo_valid = tv;
    bus.tx_fifo_data  = td;
    bus.host_we       = we;
    bus.host_re       = re;
    bus.host_addr     = addr;
    bus.host_wdata    = wd;
    bus.rx_fifo_read  = rr;
    @(posedge clk);
    #1;
    bus.tx_fifo_valid = 1'b0;
    bus.host_we       = 1'b0;
    bus.host_re       = 1'b0;
    bus.rx_fifo_read  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
    step(1'b0, 8'h00, 1'b0, 1'b1, addr, 8'h00, 1'b0);
    check(name, bus.host_rdata, exp);
  endtask

  task automatic tx_push(input logic [7:0] b);
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
    step(1'b1, b, 1'b0, 1'b0, A_DATA, 8'h00, 1'b0);
  endtask

  task automatic tx_read_sb(input string name);
    logic [7:0] exp;
    exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
    rd_check(name, A_DATA, exp);
  endtask

  task automatic rx_write(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    step(1'b0, 8'h00, 1'b1, 1'b0, A_DATA, b, 1'b0);
  endtask

  task automatic rx_pop_sb(input string name);
    if (rx_q.size() > 0) begin
      check({name, ".valid"}, {7'd0, bus.rx_fifo_valid}, 8'h01);
      check({name, ".data"}, bus.rx_fifo_data, rx_q.pop_front());
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, A_DATA, 8'h00, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[18];
    logic [7:0] b;
    logic [7:0] exp;

    bus.tx_fifo_valid = 1'b0;
    bus.tx_fifo_data  = 8'h00;
    bus.host_we       = 1'b0;
    bus.host_re       = 1'b0;
    bus.host_addr     = 2'd0;
    bus.host_wdata    = 8'h00;
    bus.rx_fifo_read  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.rdata", bus.host_rdata, 8'h00);
    check("rst.irq", {7'd0, bus.host_irq}, 8'h00);
    check("rst.txfull", {7'd0, bus.tx_fifo_full}, 8'h00);
    check("rst.rxvalid", {7'd0, bus.rx_fifo_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    //            name        tv td     we re addr    wd     rr chk erd    irq rxv rxd
    vecs[0]  = mk("v_status0", 0, 8'h00, 0, 1, A_STAT, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00);
    vecs[1]  = mk("v_push41",  1, 8'h41, 0, 0, A_DATA, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00);
    vecs[2]  = mk("v_push42",  1, 8'h42, 0, 0, A_DATA, 8'h00, 0, 1, 8'h00, 1, 0, 8'h00);
    vecs[3]  = mk("v_push43",  1, 8'h43, 0, 0, A_DATA, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00);
    vecs[4]  = mk("v_txcnt3",  0, 8'h00, 0, 1, A_TXC,  8'h00, 0, 1, 8'h03, 1, 0, 8'h00);
    vecs[5]  = mk("v_rd41",    0, 8'h00, 0, 1, A_DATA, 8'h00, 0, 1, 8'h41, 1, 0, 8'h00);
    vecs[6]  = mk("v_rd42",    0, 8'h00, 0, 1, A_DATA, 8'h00, 0, 1, 8'h42, 1, 0, 8'h00);
    vecs[7]  = mk("v_rd43",    0, 8'h00, 0, 1, A_DATA, 8'h00, 0, 1, 8'h43, 1, 0, 8'h00);
    vecs[8]  = mk("v_hold",    0, 8'h00, 0, 0, A_DATA, 8'h00, 0, 1, 8'h43, 0, 0, 8'h00);
    vecs[9]  = mk("v_rdempty", 0, 8'h00, 0, 1, A_DATA, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00);
    vecs[10] = mk("v_wr55",    0, 8'h00, 1, 0, A_DATA, 8'h55, 0, 1, 8'h00, 0, 1, 8'h55);
    vecs[11] = mk("v_wrAA",    0, 8'h00, 1, 0, A_DATA, 8'hAA, 0, 0, 8'h00, 0, 1, 8'h55);
    vecs[12] = mk("v_rxcnt2",  0, 8'h00, 0, 1, A_RXC,  8'h00, 0, 1, 8'h02, 0, 1, 8'h55);
    vecs[13] = mk("v_rxpop1",  0, 8'h00, 0, 0, A_DATA, 8'h00, 1, 0, 8'h00, 0, 1, 8'hAA);
    vecs[14] = mk("v_rxpop2",  0, 8'h00, 0, 0, A_DATA, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
    vecs[15] = mk("v_rxpopE",  0, 8'h00, 0, 0, A_DATA, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
    vecs[16] = mk("v_rxcnt0",  0, 8'h00, 0, 1, A_RXC,  8'h00, 0, 1, 8'h00, 0, 0, 8'h00);
    vecs[17] = mk("v_status1", 0, 8'h00, 0, 1, A_STAT, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].tv, vecs[i].td, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd, vecs[i].rr);
      if (vecs[i].chk) check({vecs[i].name, ".rdata"}, bus.host_rdata, vecs[i].exp_rdata);
      check({vecs[i].name, ".irq"}, {7'd0, bus.host_irq}, {7'd0, vecs[i].exp_irq});
      check({vecs[i].name, ".rxv"}, {7'd0, bus.rx_fifo_valid}, {7'd0, vecs[i].exp_rxv});
      check({vecs[i].name, ".rxd"}, bus.rx_fifo_data, vecs[i].exp_rxd);
    end

    // TX fill to threshold, full, overflow and W1C
    for (int i = 0; i < 15; i++) begin
      tx_push(8'h10 + 8'(i));
      if (i == 13) check("txfill.full_at_14", {7'd0, bus.tx_fifo_full}, 8'h00);
    end
    check("txfill.full_at_15", {7'd0, bus.tx_fifo_full}, 8'h01);
    tx_push(8'h1F);
    check("txfill.full_at_16", {7'd0, bus.tx_fifo_full}, 8'h01);
    tx_push(8'h20);
    rd_check("txfill.txcnt16", A_TXC, 8'h10);
    rd_check("txfill.status_ovf", A_STAT, 8'h15);
    if (tx_q.size() >= DEPTH) tx_q.push_back(8'h21);
    while (tx_q.size() > DEPTH) void'(tx_q.pop_back());
    step(1'b1, 8'h21, 1'b1, 1'b0, A_STAT, 8'h04, 1'b0);
    rd_check("txfill.set_wins", A_STAT, 8'h15);
    step(1'b0, 8'h00, 1'b1, 1'b0, A_STAT, 8'h04, 1'b0);
    rd_check("txfill.w1c", A_STAT, 8'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0, A_TXC, 8'h00, 1'b0);
    rd_check("txfill.txcnt_ro", A_TXC, 8'h10);
    for (int i = 0; i < DEPTH; i++) tx_read_sb("txfill.drain");
    rd_check("txfill.status_end", A_STAT, 8'h00);

    // RX full, overflow, simultaneous push/pop at full and at empty
    for (int i = 0; i < DEPTH; i++) rx_write(8'h60 + 8'(i));
    rd_check("rxfull.status", A_STAT, 8'h02);
    rd_check("rxfull.rxcnt16", A_RXC, 8'h10);
    rx_write(8'h77);
    rd_check("rxfull.status_ovf", A_STAT, 8'h0A);
    step(1'b0, 8'h00, 1'b1, 1'b0, A_STAT, 8'h08, 1'b0);
    rd_check("rxfull.w1c", A_STAT, 8'h02);
    check("rxfull.simul_head", bus.rx_fifo_data, rx_q.pop_front());
    rx_q.push_back(8'h99);
    step(1'b0, 8'h00, 1'b1, 1'b0, A_DATA, 8'h99, 1'b1);
    rd_check("rxfull.rxcnt_after", A_RXC, 8'h10);
    rd_check("rxfull.status_after", A_STAT, 8'h02);
    while (rx_q.size() > 0) rx_pop_sb("rxfull.drain");
    check("rxfull.empty", {7'd0, bus.rx_fifo_valid}, 8'h00);
    rx_q.push_back(8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, A_DATA, 8'h3C, 1'b1);
    rd_check("rxempty.simul_cnt", A_RXC, 8'h01);
    rx_pop_sb("rxempty.drain");
    check("rxempty.valid", {7'd0, bus.rx_fifo_valid}, 8'h00);

    // TX pointer wrap with interleaved reads, occupancy capped at 10
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 5);
      if ((i % 3 == 2) && (tx_q.size() > 0)) begin
        exp = tx_q.pop_front();
        tx_q.push_back(b);
        step(1'b1, b, 1'b0, 1'b1, A_DATA, 8'h00, 1'b0);
        check("wrap.simul", bus.host_rdata, exp);
      end else begin
        tx_push(b);
      end
      if (tx_q.size() >= 10) repeat (5) tx_read_sb("wrap.rd");
    end
    while (tx_q.size() > 0) tx_read_sb("wrap.drain");
    rd_check("wrap.status", A_STAT, 8'h00);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 17; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, A_DATA, 8'h00, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, 1'b1, A_DATA, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, A_DATA, 8'hE0 + 8'(i), 1'b0);
    rd_check("mid.txcnt5", A_TXC, 8'h05);
    rd_check("mid.rxcnt3", A_RXC, 8'h03);
    rd_check("mid.status", A_STAT, 8'h05);
    check("mid.irq", {7'd0, bus.host_irq}, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.rdata", bus.host_rdata, 8'h00);
    check("arst.irq", {7'd0, bus.host_irq}, 8'h00);
    check("arst.txfull", {7'd0, bus.tx_fifo_full}, 8'h00);
    check("arst.rxvalid", {7'd0, bus.rx_fifo_valid}, 8'h00);
    check("arst.rxdata", bus.rx_fifo_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete();
    rx_q.delete();
    rd_check("arst.txcnt", A_TXC, 8'h00);
    rd_check("arst.rxcnt", A_RXC, 8'h00);
    rd_check("arst.status", A_STAT, 8'h00);
    rd_check("arst.data", A_DATA, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per FIFO (power of two, 4..256).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, occupancy counter width.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tx_fifo_data  input  8  byte from UART emulation TX path.
REQ-006 tx_fifo_valid  input  1  single-cycle push strobe for tx_fifo_data.
REQ-007 tx_fifo_full  output  1  TX FIFO back-pressure to UART emulation.
REQ-008 rx_fifo_data  output  8  head byte of RX FIFO (first-word-fall-through).
REQ-009 rx_fifo_valid  output  1  RX FIFO non-empty.
REQ-010 rx_fifo_read  input  1  single-cycle pop strobe from UART emulation.
REQ-011 host_addr  input  2  host register select: 0 DATA, 1 STATUS, 2 TXCNT, 3 RXCNT.
REQ-012 host_wdata  input  8  host write data.
REQ-013 host_we  input  1  host write strobe, one cycle per access.
REQ-014 host_re  input  1  host read strobe, one cycle per access.
REQ-015 host_rdata  output  8  registered host read data.
REQ-016 host_irq  output  1  level interrupt to host: TX FIFO non-empty.

Function
REQ-017 TX FIFO: push on tx_fifo_valid; pop on host_re with host_addr=0.
REQ-018 RX FIFO: push on host_we with host_addr=0 (byte=host_wdata); pop on rx_fifo_read.
REQ-019 tx_fifo_full SHALL be 1 when TX count >= DEPTH-1 (one-slot margin for UART's registered status lag).
REQ-020 TX push with TX count = DEPTH SHALL be dropped and set sticky STATUS[2] tx_ovf.
REQ-021 RX push with RX count = DEPTH SHALL be dropped and set sticky STATUS[3] rx_ovf.
REQ-022 Pop of an empty FIFO SHALL be ignored; pointers and count unchanged.
REQ-023 Simultaneous push and pop on one FIFO SHALL both take effect; count unchanged; allowed when full (pop-then-push semantics, no overflow) and when empty (push only takes effect, count +1).
REQ-024 Read/write pointers SHALL be log2(DEPTH) bits, wrapping DEPTH-1 -> 0; counts SHALL be CW bits, range 0..DEPTH.
REQ-025 rx_fifo_data SHALL equal RX head combinationally; rx_fifo_valid = (RX count != 0); rx_fifo_data = 0x00 when empty.
REQ-026 host_rdata SHALL update the cycle after host_re (1-cycle latency) and hold otherwise.
REQ-027 DATA read SHALL return TX head byte, or 0x00 if TX empty.
REQ-028 STATUS read: [0] TX non-empty, [1] RX full (count=DEPTH), [2] tx_ovf, [3] rx_ovf, [4] tx_fifo_full, [7:5] 0.
REQ-029 TXCNT/RXCNT read SHALL return count zero-extended/truncated to 8 bits (DEPTH=256 reads 0x00 when full; STATUS[1] disambiguates RX).
REQ-030 Write to STATUS SHALL clear tx_ovf/rx_ovf where host_wdata[2]/[3] = 1 (W1C); same-cycle set wins over clear.
REQ-031 Writes to TXCNT/RXCNT SHALL be ignored; host_we and host_re in same cycle SHALL both execute.
REQ-032 host_irq SHALL be registered: 1 the cycle after TX count becomes non-zero, 0 the cycle after it returns to zero.

Reset
REQ-033 rst_n low SHALL asynchronously clear all pointers, counts, tx_ovf, rx_ovf, host_rdata (0x00), host_irq (0); tx_fifo_full=0, rx_fifo_valid=0.
REQ-034 Reset mid-operation SHALL discard all buffered bytes; FIFO storage array need not be reset.

Structure
REQ-035 Register addresses and STATUS bit positions SHALL live in shared package uart_bridge_pkg.
REQ-036 SHALL instantiate sub-module sync_fifo (parameterised width/depth, FWFT, count, full/empty) twice, TX and RX.

Verification
REQ-037 Push 0x41,0x42,0x43 via tx_fifo_valid -> host_irq=1, TXCNT=3; three DATA reads return 0x41,0x42,0x43; host_irq=0 afterwards.
REQ-038 Push 15 TX bytes (DEPTH=16) -> tx_fifo_full=1; 16th accepted, 17th dropped, STATUS=0x15; write STATUS 0x04 -> STATUS=0x11.
REQ-039 Host writes 0x55,0xAA to DATA -> rx_fifo_valid=1, rx_fifo_data=0x55; rx_fifo_read -> 0xAA next cycle; second read -> rx_fifo_valid=0.
REQ-040 RX full (16) with simultaneous host write 0x99 and rx_fifo_read -> RXCNT stays 16, rx_ovf=0, 0x99 last out.
REQ-041 Wrap: 40 bytes streamed through TX with interleaved reads, max occupancy 10 -> output order matches input, no overflow.
REQ-042 Assert rst_n low with TXCNT=5, RXCNT=3, tx_ovf=1 -> all counts 0, STATUS=0x00, host_irq=0, host_rdata=0x00 immediately.
